debounce_bank: RTL and testbench

Multi-channel switch/button debouncer, parametrised successor to the single-channel `debounce`. Each of `CH` raw inputs passes through an optional two-flop synchronizer, then through a stability counter clocked by a shared sample-tick prescaler. A channel's clean level changes only after its input has disagreed with it for `STABLE` consecutive ticks. One-cycle rise/fall pulses accompany every change. It sits between board pins (buttons/switches) and the lab control FSMs, replacing per-button `debounce` instances.

---
 rtl/debounce_bank.sv | 95 +++++++++
 tb/tb_debounce_bank.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: optional two-flop synchronizer, shared sample-tick
// prescaler and a per-channel stability counter. Sync enabled by DEBOUNCE_BANK_SYNC_EN.
module debounce_bank #(
    parameter int unsigned    CH      = 4,
    parameter int unsigned    STABLE  = 15,
    parameter int unsigned    DIV     = 1,
    parameter logic [CH-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] raw,
    output logic [CH-1:0] clean,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
);

    localparam int unsigned CW = (STABLE < 2) ? 1 : $clog2(STABLE + 1);
    localparam int unsigned DW = (DIV < 2) ? 1 : $clog2(DIV);

    logic [CH-1:0]         s;
    logic                  tick;
    logic [DW-1:0]         div_q, div_d;
    logic [CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CH-1:0]         clean_q, clean_d;
    logic [CH-1:0]         rise_q, rise_d;
    logic [CH-1:0]         fall_q, fall_d;

`ifdef DEBOUNCE_BANK_SYNC_EN
    logic [CH-1:0] sync1_q, sync2_q;

    // Reset to RST_VAL so a raw input resting at RST_VAL starts no count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = raw;
`endif

    // Prescaler; with DIV=1 the counter sits at 0 and tick is always high.
    always_comb begin
        tick  = (div_q == DW'(DIV - 1));
        div_d = tick ? '0 : div_q + DW'(1);
    end

    // Stability counters: any agreeing tick restarts the count.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        if (tick) begin
            for (int i = 0; i < int'(CH); i++) begin
                if (s[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CW'(STABLE - 1)) begin
                    clean_d[i] = s[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = s[i];
                    fall_d[i]  = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            cnt_q   <= '0;
            clean_q <= RST_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: CH=4, STABLE=15 with DIV=1 and DIV=4 instances.
module tb_debounce_bank;

    localparam int unsigned CH     = 4;
    localparam int unsigned STABLE = 15;
`ifdef DEBOUNCE_BANK_SYNC_EN
    localparam int unsigned SYNC = 2;
`else
    localparam int unsigned SYNC = 0;
`endif
    localparam int unsigned LAT = STABLE + SYNC;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] raw, clean, rise, fall;
    logic [CH-1:0] raw4, clean4, rise4, fall4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debounce_bank #(.CH(CH), .STABLE(STABLE), .DIV(1), .RST_VAL(4'b0000)) dut (
        .clk(clk), .rst(rst), .raw(raw), .clean(clean), .rise(rise), .fall(fall)
    );

    debounce_bank #(.CH(CH), .STABLE(STABLE), .DIV(4), .RST_VAL(4'b0000)) dut4 (
        .clk(clk), .rst(rst), .raw(raw4), .clean(clean4), .rise(rise4), .fall(fall4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n cycles, requiring a steady clean level and no pulses.
    task automatic quiet(input int n, input logic [CH-1:0] exp_clean, input string tag);
        for (int k = 0; k < n; k++) begin
            step();
            check({tag, " clean"}, clean, exp_clean);
            check({tag, " pulse"}, rise | fall, 4'b0000);
        end
    endtask

    task automatic expect_edge(input string tag, input logic [CH-1:0] exp_clean,
                               input logic [CH-1:0] exp_rise, input logic [CH-1:0] exp_fall);
        step();
        check({tag, " clean"}, clean, exp_clean);
        check({tag, " rise"}, rise, exp_rise);
        check({tag, " fall"}, fall, exp_fall);
        step();
        check({tag, " clean hold"}, clean, exp_clean);
        check({tag, " pulse end"}, rise | fall, 4'b0000);
    endtask

    initial begin
        int  n;
        bit  early;

        rst  = 1'b1;
        raw  = '0;
        raw4 = '0;
        #1;
        check("reset clean", clean, 4'b0000);
        check("reset rise", rise, 4'b0000);
        check("reset fall", fall, 4'b0000);
        step();
        step();
        rst = 1'b0;
        quiet(4, 4'b0000, "idle");

        // Glitch one tick short of acceptance
        raw[1] = 1'b1;
        repeat (STABLE - 1) step();
        raw[1] = 1'b0;
        quiet(LAT + 4, 4'b0000, "glitch");

        // Bounce then steady high on channel 0
        raw[0] = 1'b1;
        step();
        step();
        raw[0] = 1'b0;
        step();
        step();
        raw[0] = 1'b1;
        quiet(LAT - 1, 4'b0000, "bounce wait");
        expect_edge("bounce", 4'b0001, 4'b0001, 4'b0000);

        // Release channel 0
        raw[0] = 1'b0;
        quiet(LAT - 1, 4'b0001, "release wait");
        expect_edge("release", 4'b0000, 4'b0000, 4'b0001);

        // Simultaneous rise on channels 1 and 3
        raw = 4'b1010;
        quiet(LAT - 1, 4'b0000, "simul wait");
        expect_edge("simul", 4'b1010, 4'b1010, 4'b0000);

        // Return to all-low, then reset while channel 3 is at count 8
        raw = 4'b0000;
        repeat (LAT + 2) step();
        check("settle low", clean, 4'b0000);
        raw = 4'b1000;
        quiet(SYNC + 8, 4'b0000, "precount");
        rst = 1'b1;
        #1;
        check("midreset clean", clean, 4'b0000);
        check("midreset pulse", rise | fall, 4'b0000);
        step();
        check("in reset clean", clean, 4'b0000);
        check("in reset pulse", rise | fall, 4'b0000);
        rst = 1'b0;
        quiet(LAT - 1, 4'b0000, "postreset wait");
        expect_edge("postreset", 4'b1000, 4'b1000, 4'b0000);

        // DIV=4 instance: latency depends on prescaler phase
        raw4[2] = 1'b1;
        n       = 0;
        early   = 1'b0;
        while (clean4[2] !== 1'b1 && n < 80) begin
            step();
            n++;
            if (clean4[2] !== 1'b1 && (rise4 | fall4) !== 4'b0000) early = 1'b1;
        end
        n_checks++;
        assert (n >= int'(57 + SYNC) && n <= int'(60 + SYNC)) else begin
            n_fail++;
            $error("FAIL div4 latency: observed %0d edges expected %0d..%0d", n, 57 + SYNC, 60 + SYNC);
        end
        n_checks++;
        assert (early === 1'b0) else begin
            n_fail++;
            $error("FAIL div4 early pulse: observed %b expected 0", early);
        end
        check("div4 clean", clean4, 4'b0100);
        check("div4 rise", rise4, 4'b0100);
        check("div4 fall", fall4, 4'b0000);
        step();
        check("div4 pulse end", rise4 | fall4, 4'b0000);
        check("div4 clean hold", clean4, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
